adc_block_packer: RTL
=====================

Name: adc_block_packer

Overview:
- Sits directly downstream of the ADC SPI receiver; consumes its 12-bit samples, already in the clk domain.
- Packs a fixed number of consecutive samples plus an 8-bit header into one 128-bit block.
- Hands each block to the cipher core over a valid/ready handshake.
- Double-buffered: one assembly register plus one output register. The SPI side cannot stall, so samples that arrive when both registers are full are dropped and counted.

Parameters:
- SAMPLE_W, 12, bits per ADC sample.
- N_SAMPLES, 10, samples per full block; SAMPLE_W*N_SAMPLES must be <= BLOCK_W-8.
- BLOCK_W, 128, output block width, matching the cipher datapath.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sample  input  SAMPLE_W  ADC sample from the SPI receiver.
- sample_valid  input  1  one-cycle pulse; sample is valid this cycle.
- flush  input  1  one-cycle pulse; close the current partial block.
- block  output  BLOCK_W  packed block to the cipher core.
- block_valid  output  1  block holds an unconsumed packed block.
- block_ready  input  1  cipher core accepts block this cycle.
- overflow  output  1  sticky flag; at least one sample has been dropped.
- drop_count  output  8  dropped-sample count, saturates at 255.
- fill_level  output  4  samples currently held in the assembly register.

Behaviour:
- Reset (async assert, sync release):
  - block = 0, block_valid = 0, overflow = 0, drop_count = 0, fill_level = 0.
  - State = FILL, internal sequence counter = 0.
- Block layout:
  - Sample k occupies bits [SAMPLE_W*k+SAMPLE_W-1 : SAMPLE_W*k]; sample 0 is the first received.
  - Bits [127:124] hold the valid-sample count (N_SAMPLES, or fewer on flush).
  - Bits [123:120] are the sequence field (see Optional Feature).
  - Unused slots and pad bits are 0.
- fire = block_valid & block_ready. The output slot is free in a cycle if block_valid==0 or fire==1.
- State FILL (the assembly register is accepting samples):
  - On sample_valid, write sample into slot fill_level and increment fill_level.
  - If that sample fills slot N_SAMPLES-1:
    - Output slot free: load the block (including this sample) into block on the same edge. block_valid = 1 the next cycle (1-cycle latency). fill_level -> 0; stay in FILL.
    - Output slot not free: go to PEND; fill_level stays at N_SAMPLES.
  - flush with fill_level > 0 (after any same-cycle sample write) closes a partial block:
    - Header count = number of samples held; the block is handled as complete by the same rules above.
  - flush with fill_level == 0 and no same-cycle sample: ignored.
- State PEND (a complete block waits for the output slot):
  - When the output slot is free, load the pending block into block, set block_valid, fill_level -> 0, go to FILL.
  - Every sample_valid in PEND is dropped, including on the transfer cycle.
  - On each dropped sample: overflow = 1, and drop_count increments, saturating at 255.
  - flush in PEND: ignored.
- Output register:
  - block is stable while block_valid=1 and block_ready=0.
  - On fire with no reload, block_valid goes to 0 the next cycle; block keeps its last value.
  - On fire with a same-cycle reload, block_valid stays 1 and block takes the new block.
- overflow and drop_count clear only on reset.
- Reset mid-block discards both the partial assembly and any pending output block.

Optional Feature:
- Macro: PACK_SEQ_EN.
- Defined:
  - Bits [123:120] carry a 4-bit sequence number.
  - It starts at 0 after reset and increments each time a block loads into the output register, wrapping 15 -> 0.
  - The cipher core uses it to detect dropped blocks.
- Undefined: bits [123:120] are always 0 and no sequence counter is built.

Test Plan:
- Reset, then 10 samples 0x001..0x00A with block_ready=1 -> one cycle after the 10th sample: block_valid=1, block[11:0]=0x001, block[119:108]=0x00A, block[127:124]=0xA. With PACK_SEQ_EN, bits [123:120]=0x0.
- 3 samples 0xFFF, then flush -> block[35:0]=all ones, block[119:36]=0, block[127:124]=0x3, fill_level=0.
- block_ready=0, feed 20 samples -> first block held stable, second block in PEND (fill_level=10), drop_count=0. Feed 3 more -> drop_count=3, overflow=1.
- From that state raise block_ready for 1 cycle -> next cycle block = second block, block_valid stays 1, fill_level=0.
- Hold block_ready=0 and feed 300 extra samples -> drop_count saturates at 255.
- Assert reset mid-block with fill_level=5 and block_valid=1 -> all outputs 0 immediately. After release, a new 10-sample block has count 0xA and (with PACK_SEQ_EN) seq 0x0.

Source files
------------

// File: rtl/adc_block_packer_if.sv
// Sample-in / block-out bus of adc_block_packer.
// master: packer side (consumes samples, drives blocks and status).
// slave : environment side (SPI receiver, cipher core, monitors).
interface adc_block_packer_if #(
  parameter int SAMPLE_W = 12,
  parameter int BLOCK_W  = 128
);
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                flush;
  logic [BLOCK_W-1:0]  block;
  logic                block_valid;
  logic                block_ready;
  logic                overflow;
  logic [7:0]          drop_count;
  logic [3:0]          fill_level;

  modport master (
    input  sample, sample_valid, flush, block_ready,
    output block, block_valid, overflow, drop_count, fill_level
  );

  modport slave (
    output sample, sample_valid, flush, block_ready,
    input  block, block_valid, overflow, drop_count, fill_level
  );
endinterface

// File: rtl/adc_block_packer.sv
// adc_block_packer: packs N_SAMPLES ADC samples plus a count/sequence header
// into one BLOCK_W block, double-buffered (assembly + output register).
// Samples arriving while both registers are full are dropped and counted.
// Optional macro PACK_SEQ_EN: when defined, bits [BLOCK_W-5 -: 4] carry a
// 4-bit sequence number incremented per loaded block; otherwise they are 0.
module adc_block_packer #(
  parameter int SAMPLE_W  = 12,
  parameter int N_SAMPLES = 10,
  parameter int BLOCK_W   = 128
) (
  input  logic              clk,
  input  logic              reset,
  adc_block_packer_if.master bus
);
  localparam int ASM_W = SAMPLE_W * N_SAMPLES;

  typedef enum logic {FILL = 1'b0, PEND = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [ASM_W-1:0]   asm_q, asm_nxt;
  logic [3:0]         fill_q, fill_after;
  logic [3:0]         seq_cur;
  logic [BLOCK_W-1:0] block_q, load_block;
  logic               block_valid_q;
  logic               overflow_q;
  logic [7:0]         drop_q;
  logic               wr, close, fire, slot_free, load, drop;

  // Header in the top byte: valid-sample count, then sequence number.
  // Slots at or beyond the count are forced to zero, so stale assembly
  // contents never leak into a partial block.
  function automatic logic [BLOCK_W-1:0] pack_block(input logic [ASM_W-1:0] slots,
                                                    input logic [3:0] cnt,
                                                    input logic [3:0] seq);
    logic [BLOCK_W-1:0] res;
    res = '0;
    for (int k = 0; k < N_SAMPLES; k++) begin
      if (k < int'(cnt)) res[k*SAMPLE_W +: SAMPLE_W] = slots[k*SAMPLE_W +: SAMPLE_W];
    end
    res[BLOCK_W-1 -: 4] = cnt;
    res[BLOCK_W-5 -: 4] = seq;
    return res;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fire       = block_valid_q & bus.block_ready;
  assign slot_free  = ~block_valid_q | fire;
  assign wr         = (state == FILL) & bus.sample_valid;
  assign fill_after = fill_q + 4'(wr);
  assign close      = (state == FILL) &
                      ((fill_after == 4'(N_SAMPLES)) | (bus.flush & (fill_after != 4'd0)));

  // Assembly register image after this cycle's sample write.
  always_comb begin
    asm_nxt = asm_q;
    if (wr) asm_nxt[int'(fill_q)*SAMPLE_W +: SAMPLE_W] = bus.sample;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // FSM next state: park a closed block in PEND until the output slot frees.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close && !slot_free) state_nxt = PEND;
      PEND:    if (slot_free)           state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // FSM outputs: when to load the output register, what to load, when to drop.
  always_comb begin
    load       = 1'b0;
    drop       = 1'b0;
    load_block = pack_block(asm_q, fill_q, seq_cur);
    case (state)
      FILL: begin
        load       = close & slot_free;
        load_block = pack_block(asm_nxt, fill_after, seq_cur);
      end
      PEND: begin
        load = slot_free;
        drop = bus.sample_valid;
      end
      default: ;
    endcase
  end

  // Assembly slots are pure data and need no reset; the count masks them.
  always_ff @(posedge clk) begin
    asm_q <= asm_nxt;
  end

  // Fill level, output register, drop accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q        <= '0;
      block_q       <= '0;
      block_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_q        <= '0;
    end else begin
      if (load)               fill_q <= '0;
      else if (state == FILL) fill_q <= fill_after;
      if (load) begin
        block_q       <= load_block;
        block_valid_q <= 1'b1;
      end else if (fire) begin
        block_valid_q <= 1'b0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        drop_q     <= sat_inc8(drop_q);
      end
    end
  end

`ifdef PACK_SEQ_EN
  logic [3:0] seq_q;

  // Sequence number advances once per block loaded into the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    seq_q <= '0;
    else if (load) seq_q <= seq_q + 4'd1;
  end

  assign seq_cur = seq_q;
`else
  assign seq_cur = 4'd0;
`endif

  assign bus.block       = block_q;
  assign bus.block_valid = block_valid_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_q;
  assign bus.fill_level  = fill_q;
endmodule
